// File: rtl/rpn_pkg.sv
// Shared opcodes, error codes and FSM states for the RPN calculator.
// RPN_CALC_DIV_EN adds opcode 101 (unsigned divide) to the binary operator set.
package rpn_pkg;

  localparam logic [2:0] OP_MUL = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_EQ  = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;
  localparam logic [1:0] ERR_DIV0 = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_ACK,
    S_RESULT,
    S_WAIT_ACK
  } state_e;

  function automatic logic is_binop(input logic [2:0] op);
`ifdef RPN_CALC_DIV_EN
    return (op == OP_MUL) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_DIV);
`else
    return (op == OP_MUL) || (op == OP_ADD) || (op == OP_SUB);
`endif
  endfunction

endpackage

// File: rtl/rpn_stack.sv
// Operand stack: register array plus occupancy counter.
// Priority: clear > replace-top-two > push > pop; a push into a full stack is dropped.
module rpn_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         repl_i,
  input  logic                         clr_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic [WIDTH-1:0]             top_o,
  output logic [WIDTH-1:0]             nxt_o,
  output logic [$clog2(DEPTH+1)-1:0]   depth_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    top_idx, nxt_idx, wr_idx;
  logic             wr_en;

  assign top_idx = AW'(cnt_q - DW'(1));
  assign nxt_idx = AW'(cnt_q - DW'(2));
  assign top_o   = mem_q[top_idx];
  assign nxt_o   = mem_q[nxt_idx];
  assign depth_o = cnt_q;

  always_comb begin
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = AW'(cnt_q);
    if (clr_i) begin
      cnt_d = '0;
    end else if (repl_i && cnt_q >= DW'(2)) begin
      // result lands in the left operand's slot, right operand is dropped
      wr_en  = 1'b1;
      wr_idx = nxt_idx;
      cnt_d  = cnt_q - DW'(1);
    end else if (push_i && cnt_q < DW'(DEPTH)) begin
      wr_en = 1'b1;
      cnt_d = cnt_q + DW'(1);
    end else if (pop_i && cnt_q != '0) begin
      cnt_d = cnt_q - DW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_idx] <= wdata_i;
  end

endmodule

// File: rtl/rpn_calc_param.sv
// Token-driven RPN calculator: operands push, operators reduce the top two entries.
// Define RPN_CALC_DIV_EN to add an iterative unsigned divider for opcode 101.
module rpn_calc_param
  import rpn_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         in_stb,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_is_op,
  output logic                         in_ack,
  output logic                         out_stb,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_err,
  output logic [1:0]                   out_err_code,
  input  logic                         out_ack,
  output logic [$clog2(DEPTH+1)-1:0]   depth
);

  localparam int DW = $clog2(DEPTH+1);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic             in_ack_q, in_ack_d;
  logic             out_stb_q, out_stb_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_err_q, out_err_d;
  logic [1:0]       out_code_q, out_code_d;

  logic             st_push, st_repl, st_clr;
  logic [WIDTH-1:0] st_wdata, st_top, st_nxt;
  logic [DW-1:0]    st_depth;

  logic             go_res;
  logic [1:0]       res_code;
  logic [WIDTH-1:0] res_data;
  logic [WIDTH-1:0] alu_res;

  rpn_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (st_push),
    .pop_i   (1'b0),
    .repl_i  (st_repl),
    .clr_i   (st_clr),
    .wdata_i (st_wdata),
    .top_o   (st_top),
    .nxt_o   (st_nxt),
    .depth_o (st_depth)
  );

  always_comb begin
    unique case (op_q)
      OP_MUL:  alu_res = st_nxt * st_top;
      OP_ADD:  alu_res = st_nxt + st_top;
      OP_SUB:  alu_res = st_nxt - st_top;
      default: alu_res = '0;
    endcase
  end

`ifdef RPN_CALC_DIV_EN
  localparam int CW = $clog2(WIDTH+1);

  logic             div_busy_q, div_busy_d;
  logic [WIDTH-1:0] quo_q, quo_d, quo_nx;
  logic [WIDTH-1:0] rem_q, rem_d, rem_nx;
  logic [CW-1:0]    dcnt_q, dcnt_d;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;

  // one restoring shift-subtract step per cycle; the divisor stays on the stack top
  always_comb begin
    div_sh = {rem_q, quo_q[WIDTH-1]};
    div_ge = div_sh >= {1'b0, st_top};
    rem_nx = div_ge ? WIDTH'(div_sh - {1'b0, st_top}) : div_sh[WIDTH-1:0];
    quo_nx = {quo_q[WIDTH-2:0], div_ge};
  end
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    in_ack_d   = 1'b0;
    out_stb_d  = out_stb_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    out_code_d = out_code_q;
    st_push    = 1'b0;
    st_repl    = 1'b0;
    st_clr     = 1'b0;
    st_wdata   = in_data;
    go_res     = 1'b0;
    res_code   = ERR_NONE;
    res_data   = '0;
`ifdef RPN_CALC_DIV_EN
    div_busy_d = div_busy_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dcnt_d     = dcnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_stb) begin
          if (!in_is_op) begin
            if (st_depth < DW'(DEPTH)) begin
              st_push  = 1'b1;
              in_ack_d = 1'b1;
              state_d  = S_ACK;
            end else begin
              go_res   = 1'b1;
              res_code = ERR_OVF;
            end
          end else if (in_data[2:0] == OP_EQ) begin
            go_res = 1'b1;
            if (st_depth == '0) res_code = ERR_UNF;
            else                res_data = st_top;
          end else if (is_binop(in_data[2:0])) begin
            if (st_depth < DW'(2)) begin
              go_res   = 1'b1;
              res_code = ERR_UNF;
            end else begin
              op_d    = in_data[2:0];
              state_d = S_EXEC;
            end
          end else begin
            go_res   = 1'b1;
            res_code = ERR_UNF;
          end
        end
      end
      S_EXEC: begin
`ifdef RPN_CALC_DIV_EN
        if (op_q == OP_DIV) begin
          if (!div_busy_q) begin
            if (st_top == '0) begin
              go_res   = 1'b1;
              res_code = ERR_DIV0;
            end else begin
              div_busy_d = 1'b1;
              quo_d      = st_nxt;
              rem_d      = '0;
              dcnt_d     = CW'(WIDTH);
            end
          end else begin
            quo_d  = quo_nx;
            rem_d  = rem_nx;
            dcnt_d = dcnt_q - CW'(1);
            if (dcnt_q == CW'(1)) begin
              st_repl    = 1'b1;
              st_wdata   = quo_nx;
              div_busy_d = 1'b0;
              in_ack_d   = 1'b1;
              state_d    = S_ACK;
            end
          end
        end else
`endif
        begin
          st_repl  = 1'b1;
          st_wdata = alu_res;
          in_ack_d = 1'b1;
          state_d  = S_ACK;
        end
      end
      S_ACK: state_d = S_IDLE;
      S_RESULT: begin
        // every reported result, good or bad, empties the stack
        st_clr  = 1'b1;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (out_ack) begin
          out_stb_d  = 1'b0;
          out_data_d = '0;
          out_err_d  = 1'b0;
          out_code_d = ERR_NONE;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (go_res) begin
      state_d    = S_RESULT;
      in_ack_d   = 1'b1;
      out_stb_d  = 1'b1;
      out_err_d  = (res_code != ERR_NONE);
      out_code_d = res_code;
      out_data_d = res_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      in_ack_q   <= 1'b0;
      out_stb_q  <= 1'b0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
      out_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      in_ack_q   <= in_ack_d;
      out_stb_q  <= out_stb_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
      out_code_q <= out_code_d;
    end
  end

`ifdef RPN_CALC_DIV_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      div_busy_q <= 1'b0;
      quo_q      <= '0;
      rem_q      <= '0;
      dcnt_q     <= '0;
    end else begin
      div_busy_q <= div_busy_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dcnt_q     <= dcnt_d;
    end
  end
`endif

  assign in_ack       = in_ack_q;
  assign out_stb      = out_stb_q;
  assign out_data     = out_data_q;
  assign out_err      = out_err_q;
  assign out_err_code = out_code_q;
  assign depth        = st_depth;

endmodule

// File: tb/tb_rpn_calc_param.sv
// Directed bench for rpn_calc_param (WIDTH=32, DEPTH=4); follows RPN_CALC_DIV_EN for divide expectations.
module tb_rpn_calc_param;

  localparam logic [31:0] OPMUL = 32'd1;
  localparam logic [31:0] OPADD = 32'd2;
  localparam logic [31:0] OPSUB = 32'd3;
  localparam logic [31:0] OPEQ  = 32'd4;
  localparam logic [31:0] OPDIV = 32'd5;
  localparam logic [31:0] OPBAD = 32'd7;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_stb = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_is_op = 1'b0;
  logic        in_ack;
  logic        out_stb;
  logic [31:0] out_data;
  logic        out_err;
  logic [1:0]  out_err_code;
  logic        out_ack = 1'b0;
  logic [2:0]  depth;

  int checks = 0;
  int failures = 0;

  rpn_calc_param #(.WIDTH(32), .DEPTH(4)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .in_stb       (in_stb),
    .in_data      (in_data),
    .in_is_op     (in_is_op),
    .in_ack       (in_ack),
    .out_stb      (out_stb),
    .out_data     (out_data),
    .out_err      (out_err),
    .out_err_code (out_err_code),
    .out_ack      (out_ack),
    .depth        (depth)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // drive one token until acknowledged, then idle one cycle
  task automatic send(input logic op, input logic [31:0] d, output int lat);
    in_stb = 1'b1; in_is_op = op; in_data = d; lat = 0;
    do begin
      @(posedge CLK); #1; lat++;
    end while (!in_ack && lat < 100);
    if (!in_ack) begin
      checks++; failures++;
      $display("FAIL send_timeout in_ack=%b required=1", in_ack);
    end
    in_stb = 1'b0; in_is_op = 1'b0; in_data = '0;
    @(posedge CLK); #1;
  endtask

  task automatic get_result(output logic [31:0] d, output logic e, output logic [1:0] c);
    int n = 0;
    while (!out_stb && n < 100) begin @(posedge CLK); #1; n++; end
    d = out_data; e = out_err; c = out_err_code;
    out_ack = 1'b1; n = 0;
    do begin
      @(posedge CLK); #1; n++;
    end while (out_stb && n < 100);
    out_ack = 1'b0;
    if (out_stb) begin
      checks++; failures++;
      $display("FAIL result_timeout out_stb=%b required=0", out_stb);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({out_stb, in_ack, out_err, out_err_code, depth} !== 8'd0 || out_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_state stb=%b ack=%b err=%b code=%b depth=%0d data=%h required all zero",
               out_stb, in_ack, out_err, out_err_code, depth, out_data);
    end
    RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_add();
    int lat; logic [31:0] d; logic e; logic [1:0] c;
    send(1'b0, 32'd3, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL push_latency got=%0d required=1", lat); end
    send(1'b0, 32'd4, lat);
    send(1'b1, OPADD, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL op_latency got=%0d required=2", lat); end
    checks++; if (depth !== 3'd1) begin failures++; $display("FAIL add_depth got=%0d required=1", depth); end
    send(1'b1, OPEQ, lat);
    get_result(d, e, c);
    checks++; if (d !== 32'd7 || e !== 1'b0 || c !== 2'b00) begin
      failures++; $display("FAIL add_result got=%h/%b/%b required=00000007/0/00", d, e, c);
    end
    checks++; if (depth !== 3'd0) begin failures++; $display("FAIL add_depth_after got=%0d required=0", depth); end
  endtask

  task automatic test_sub_mul();
    int lat; logic [31:0] d; logic e; logic [1:0] c;
    send(1'b0, 32'd3, lat); send(1'b0, 32'd5, lat); send(1'b1, OPSUB, lat); send(1'b1, OPEQ, lat);
    get_result(d, e, c);
    checks++; if (d !== 32'hFFFF_FFFE || e !== 1'b0) begin
      failures++; $display("FAIL sub_wrap got=%h/%b required=fffffffe/0", d, e);
    end
    send(1'b0, 32'h0001_0000, lat); send(1'b0, 32'h0001_0000, lat); send(1'b1, OPMUL, lat); send(1'b1, OPEQ, lat);
    get_result(d, e, c);
    checks++; if (d !== 32'd0 || e !== 1'b0) begin
      failures++; $display("FAIL mul_trunc got=%h/%b required=00000000/0", d, e);
    end
    // 2 + (3 * 4)
    send(1'b0, 32'd2, lat); send(1'b0, 32'd3, lat); send(1'b0, 32'd4, lat);
    send(1'b1, OPMUL, lat); send(1'b1, OPADD, lat); send(1'b1, OPEQ, lat);
    get_result(d, e, c);
    checks++; if (d !== 32'd14 || e !== 1'b0) begin
      failures++; $display("FAIL chain_result got=%0d/%b required=14/0", d, e);
    end
  endtask

  task automatic test_overflow();
    int lat; logic [31:0] d; logic e; logic [1:0] c;
    for (int i = 1; i <= 4; i++) send(1'b0, 32'(i), lat);
    checks++; if (depth !== 3'd4) begin failures++; $display("FAIL full_depth got=%0d required=4", depth); end
    send(1'b0, 32'd5, lat);
    get_result(d, e, c);
    checks++; if (d !== 32'd0 || e !== 1'b1 || c !== 2'b01) begin
      failures++; $display("FAIL overflow got=%h/%b/%b required=00000000/1/01", d, e, c);
    end
    checks++; if (depth !== 3'd0) begin failures++; $display("FAIL overflow_depth got=%0d required=0", depth); end
  endtask

  task automatic test_underflow();
    int lat; logic [31:0] d; logic e; logic [1:0] c;
    send(1'b0, 32'd9, lat); send(1'b1, OPMUL, lat);
    get_result(d, e, c);
    checks++; if (e !== 1'b1 || c !== 2'b10 || d !== 32'd0) begin
      failures++; $display("FAIL mul_underflow got=%h/%b/%b required=00000000/1/10", d, e, c);
    end
    send(1'b1, OPEQ, lat);
    get_result(d, e, c);
    checks++; if (e !== 1'b1 || c !== 2'b10) begin
      failures++; $display("FAIL eq_empty got=%b/%b required=1/10", e, c);
    end
    send(1'b0, 32'd1, lat); send(1'b0, 32'd2, lat); send(1'b1, OPBAD, lat);
    get_result(d, e, c);
    checks++; if (e !== 1'b1 || c !== 2'b10 || depth !== 3'd0) begin
      failures++; $display("FAIL illegal_op got=%b/%b depth=%0d required=1/10 depth=0", e, c, depth);
    end
  endtask

  task automatic test_div();
    int lat; logic [31:0] d; logic e; logic [1:0] c;
    send(1'b0, 32'd17, lat); send(1'b0, 32'd5, lat); send(1'b1, OPDIV, lat);
`ifdef RPN_CALC_DIV_EN
    checks++; if (lat < 2 || lat > 34) begin failures++; $display("FAIL div_latency got=%0d required=2..34", lat); end
    checks++; if (depth !== 3'd1) begin failures++; $display("FAIL div_depth got=%0d required=1", depth); end
    send(1'b1, OPEQ, lat);
    get_result(d, e, c);
    checks++; if (d !== 32'd3 || e !== 1'b0) begin failures++; $display("FAIL div_result got=%0d/%b required=3/0", d, e); end
    send(1'b0, 32'hFFFF_FFFF, lat); send(1'b0, 32'd16, lat); send(1'b1, OPDIV, lat); send(1'b1, OPEQ, lat);
    get_result(d, e, c);
    checks++; if (d !== 32'h0FFF_FFFF || e !== 1'b0) begin failures++; $display("FAIL div_big got=%h/%b required=0fffffff/0", d, e); end
    send(1'b0, 32'd1, lat); send(1'b0, 32'd0, lat); send(1'b1, OPDIV, lat);
    get_result(d, e, c);
    checks++; if (d !== 32'd0 || e !== 1'b1 || c !== 2'b11) begin
      failures++; $display("FAIL div_zero got=%h/%b/%b required=00000000/1/11", d, e, c);
    end
`else
    get_result(d, e, c);
    checks++; if (e !== 1'b1 || c !== 2'b10) begin failures++; $display("FAIL div_disabled got=%b/%b required=1/10", e, c); end
`endif
    checks++; if (depth !== 3'd0) begin failures++; $display("FAIL div_depth_after got=%0d required=0", depth); end
  endtask

  task automatic test_hold_and_reset();
    int lat; logic [31:0] d; logic e; logic [1:0] c;
    int bad = 0;
    send(1'b0, 32'd5, lat); send(1'b1, OPEQ, lat);
    for (int i = 0; i < 10; i++) begin
      if (out_stb !== 1'b1 || out_data !== 32'd5 || out_err !== 1'b0) bad++;
      @(posedge CLK); #1;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL hold_stable bad_cycles=%0d required=0", bad); end
    RST = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if ({out_stb, in_ack, out_err, out_err_code, depth} !== 8'd0 || out_data !== 32'd0) begin
      failures++; $display("FAIL reset_wait_ack stb=%b data=%h err=%b code=%b depth=%0d required zeros",
                           out_stb, out_data, out_err, out_err_code, depth);
    end
    RST = 1'b0;
    @(posedge CLK); #1;
    // reset mid-operator
    send(1'b0, 32'd1, lat); send(1'b0, 32'd2, lat);
    in_stb = 1'b1; in_is_op = 1'b1; in_data = OPADD;
    @(posedge CLK); #1;
    RST = 1'b1; in_stb = 1'b0; in_is_op = 1'b0; in_data = '0;
    @(posedge CLK); #1;
    checks++;
    if ({out_stb, in_ack, out_err, out_err_code, depth} !== 8'd0 || out_data !== 32'd0) begin
      failures++; $display("FAIL reset_exec stb=%b ack=%b depth=%0d required zeros", out_stb, in_ack, depth);
    end
    RST = 1'b0;
    @(posedge CLK); #1;
    send(1'b0, 32'd6, lat); send(1'b0, 32'd7, lat); send(1'b1, OPMUL, lat); send(1'b1, OPEQ, lat);
    get_result(d, e, c);
    checks++; if (d !== 32'd42 || e !== 1'b0) begin failures++; $display("FAIL post_reset_mul got=%0d/%b required=42/0", d, e); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] d; logic e; logic [1:0] c;
    send(1'b0, 32'd8, lat); send(1'b1, OPEQ, lat);
    in_stb = 1'b1; in_is_op = 1'b0; in_data = 32'd11; out_ack = 1'b1;
    @(posedge CLK); #1;
    checks++; if (out_stb !== 1'b0 || in_ack !== 1'b0 || depth !== 3'd0) begin
      failures++; $display("FAIL simul_ack stb=%b ack=%b depth=%0d required=0/0/0", out_stb, in_ack, depth);
    end
    out_ack = 1'b0;
    @(posedge CLK); #1;
    checks++; if (in_ack !== 1'b1 || depth !== 3'd1) begin
      failures++; $display("FAIL deferred_push ack=%b depth=%0d required=1/1", in_ack, depth);
    end
    in_stb = 1'b0; in_data = '0;
    @(posedge CLK); #1;
    send(1'b1, OPEQ, lat);
    get_result(d, e, c);
    checks++; if (d !== 32'd11 || e !== 1'b0) begin failures++; $display("FAIL deferred_result got=%0d/%b required=11/0", d, e); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_mul();
    test_overflow();
    test_underflow();
    test_div();
    test_hold_and_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
